// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect arbitration: jr over jump over branch, target forced word-aligned.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic            jr,
    input  logic [XLEN-1:0] jr_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_target
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        raw_target = branch_target;
        if (jr) begin
            raw_target = jr_target;
        end else if (jump) begin
            raw_target = jump_target;
        end
    end

    assign redirect        = jr | jump | branch_taken;
    assign redirect_target = word_align(raw_target);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, handshakes with instruction memory and
// hands one instruction at a time to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] instr,
    output logic              instr_valid,
    input  logic              id_stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] instr_next;
    logic              pend, pend_next;
    logic [ADDR_W-1:0] pend_target, pend_target_next;
    logic              req_next, valid_next;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;

    next_pc_sel u_next_pc_sel (
        .jr              (jr),
        .jr_target       (jr_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            pend        <= 1'b0;
            pend_target <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            pend        <= pend_next;
            pend_target <= pend_target_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
        end
    end

    // A redirect arriving mid-wait is parked; the transfer in flight is never aborted.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        pend_next        = pend;
        pend_target_next = pend_target;

        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_next   = redirect_target;
                        pend_next = 1'b0;
                    end else if (pend) begin
                        pc_next   = pend_target;
                        pend_next = 1'b0;
                    end else begin
                        instr_next = imem_rdata;
                        state_next = VALID;
                    end
                end else if (redirect) begin
                    pend_next        = 1'b1;
                    pend_target_next = redirect_target;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (!id_stall) begin
                    pc_next    = pc + ADDR_W'(WORD_BYTES);
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        req_next   = (state_next == REQ);
        valid_next = (state_next == VALID);
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = pc + ADDR_W'(WORD_BYTES);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the fetch PC and sequences it against the instruction memory through a req/ready handshake. It selects the next PC: sequential +4, branch target, jump target or register target (jr). It holds the PC while decode stalls and delivers one instruction at a time to the decode stage with a valid flag. It sits between the branch/jump resolution logic, the instruction memory and decode in the MIPS-style core.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
ADDR_W, 32, address/instruction width (fixed at 32 for this core)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (equals pc_out while imem_req=1)
imem_ready  in  1  memory accepts/returns; transfer when imem_req & imem_ready
imem_rdata  in  32  instruction word, valid in the transfer cycle
instr  out  32  instruction delivered to decode
instr_valid  out  1  instr is valid for decode
id_stall  in  1  decode cannot consume this cycle
branch_taken  in  1  redirect request, branch
branch_target  in  32  branch target address
jump  in  1  redirect request, j/jal
jump_target  in  32  jump target address
jr  in  1  redirect request, jr
jr_target  in  32  register target address
pc_out  out  32  address of current fetch/delivered instruction
pc_plus4  out  32  pc_out + 4, mod 2^32 (for jal link)

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, redirect-pending flag=0. Effect is immediate; no clock edge is required.
- Reset mid-transfer: the outstanding request is abandoned and imem_req drops immediately. Instruction memory must tolerate the dropped request.
- States: IDLE, REQ, VALID.
- IDLE: lasts one cycle after reset release, then moves to REQ.
- REQ: imem_req=1, imem_addr=pc. imem_req stays high until imem_ready is sampled high.
  - ready=1 and no redirect pending or present: latch instr<=imem_rdata and go to VALID. pc is unchanged.
  - ready=1 with a redirect pending or present: discard the data, set pc<=target, clear the pending flag, stay in REQ. The next cycle fetches the new address.
  - ready=0 with a redirect present: latch the target into the pending register and set the pending flag. A later redirect overwrites an earlier one. The current transfer is never aborted.
- VALID: instr_valid=1; instr and pc_out are held stable.
  - redirect present: drop the instruction, set pc<=target, go to REQ (instr_valid=0 next cycle).
  - else if id_stall=0: the instruction is consumed; pc<=pc+4, go to REQ.
  - else: hold in VALID.
- Redirect priority: jr > jump > branch_taken.
- Targets are forced word-aligned (bits[1:0] cleared).
- pc+4 wraps: 0xFFFF_FFFC -> 0x0000_0000.
- Latency:
  - First request is in the 2nd cycle after reset release.
  - With a zero-wait memory, instr_valid is asserted the cycle after the transfer.
  - Peak throughput is 1 instruction per 2 cycles.
  - Redirect-to-request is 1 cycle.
- imem_addr is driven from pc in all states. It is only meaningful while imem_req=1.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding enum: IDLE=2'd0, REQ=2'd1, VALID=2'd2
  - constant WORD_BYTES=4
  - alignment mask 32'hFFFF_FFFC
- One sub-module: next_pc_sel. It is combinational and does priority select plus alignment of jr/jump/branch targets, producing redirect and redirect_target. The FSM, pc register, pending register and instr latch stay in fetch_sequencer.

Test Plan:
1. RESET_PC=0x0040_0000, imem_ready tied 1, rdata=0x2008_000A:
   - imem_req=1 with addr 0x0040_0000 in the 2nd cycle after reset release.
   - Next cycle: instr_valid=1, instr=0x2008_000A, pc_out=0x0040_0000, pc_plus4=0x0040_0004.
   - Following request is at 0x0040_0004.
2. id_stall=1 for 3 cycles during VALID: instr_valid and instr stay stable for those 3 cycles with imem_req=0. After release, the next request is at pc+4.
3. branch_taken=1 with target 0x0040_0020 while in VALID: next cycle instr_valid=0, imem_req=1, addr=0x0040_0020.
4. imem_ready delayed 3 cycles; jump to 0x0040_0100 asserted in the 1st wait cycle:
   - The transfer completes with no instr_valid.
   - The next cycle requests 0x0040_0100.
5. jr, jump and branch asserted in the same cycle with targets 0x0040_0013, 0x0040_0200 and 0x0040_0300: the redirect goes to 0x0040_0010 (jr wins; address aligned).
6. Wrap and async reset:
   - pc=0xFFFF_FFFC consumed: the next request is at 0x0000_0000.
   - reset asserted mid-wait, between clock edges: imem_req and instr_valid drop immediately, and pc=RESET_PC.
